// File: rtl/shift_pkg.sv
// Shared constants and types for the execute-stage shifter scheduler.
package shift_pkg;

    localparam int DATA_W = 32;
    localparam int AMT_W  = 8;

    localparam logic [1:0] SRTYPE_LSL = 2'b00;
    localparam logic [1:0] SRTYPE_LSR = 2'b01;
    localparam logic [1:0] SRTYPE_ASR = 2'b10;
    localparam logic [1:0] SRTYPE_ROR = 2'b11;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              carry;
    } sh_res_t;

    typedef enum logic {ST_EMPTY, ST_FULL} buf_state_e;

endpackage

// File: rtl/shift_arb_shifter.sv
// Combinational barrel shifter for offsets 0..31; offset 0 passes operand and carry through.
module shift_arb_shifter
    import shift_pkg::*;
(
    input  logic [1:0]        s_type,
    input  logic [4:0]        offset,
    input  logic [DATA_W-1:0] op_m,
    input  logic              carry_in,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    logic [5:0]        inv_off;
    logic [4:0]        dec_off;
    logic [DATA_W-1:0] rot;

    always_comb begin
        inv_off = 6'd32 - {1'b0, offset};
        dec_off = offset - 5'd1;
        rot     = (op_m >> offset) | (op_m << inv_off);
        result  = op_m;
        carry   = carry_in;
        if (offset != 5'd0) begin
            unique case (s_type)
                SRTYPE_LSL: begin
                    result = op_m << offset;
                    carry  = op_m[inv_off[4:0]];
                end
                SRTYPE_LSR: begin
                    result = op_m >> offset;
                    carry  = op_m[dec_off];
                end
                SRTYPE_ASR: begin
                    result = $unsigned($signed(op_m) >>> offset);
                    carry  = op_m[dec_off];
                end
                default: begin
                    result = rot;
                    carry  = rot[DATA_W-1];
                end
            endcase
        end
    end

endmodule

// File: rtl/shift_arb.sv
// Round-robin scheduler sharing one shifter between two requesters, with a one-entry
// registered result buffer and ARM amount decode wrapped around the shifter.
module shift_arb
    import shift_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [1:0]                  rq_valid,
    output logic [1:0]                  rq_ready,
    input  logic [1:0][1:0]             rq_type,
    input  logic [1:0]                  rq_is_reg,
    input  logic [1:0][AMT_W-1:0]       rq_amt,
    input  logic [1:0][DATA_W-1:0]      rq_op,
    input  logic [1:0]                  rq_cin,
    output logic                        rs_valid,
    input  logic                        rs_ready,
    output logic                        rs_id,
    output logic [DATA_W-1:0]           rs_data,
    output logic                        rs_carry
);

    // Special-case amounts are resolved here; in-range shifts come from the shifter.
    function automatic sh_res_t shift_decode(
        input logic [1:0]        t,
        input logic              is_reg,
        input logic [AMT_W-1:0]  a,
        input logic [DATA_W-1:0] op,
        input logic              cin,
        input sh_res_t           sh
    );
        sh_res_t r;
        r = sh;
        if (is_reg) begin
            if (a == '0) begin
                r = '{data: op, carry: cin};
            end else begin
                unique case (t)
                    SRTYPE_LSL: if (a == 8'd32) r = '{data: '0, carry: op[0]};
                                else if (a > 8'd32) r = '{data: '0, carry: 1'b0};
                    SRTYPE_LSR: if (a == 8'd32) r = '{data: '0, carry: op[DATA_W-1]};
                                else if (a > 8'd32) r = '{data: '0, carry: 1'b0};
                    SRTYPE_ASR: if (a >= 8'd32)
                                    r = '{data: {DATA_W{op[DATA_W-1]}}, carry: op[DATA_W-1]};
                    default:    if (a[4:0] == 5'd0) r = '{data: op, carry: op[DATA_W-1]};
                endcase
            end
        end else if (a[4:0] == 5'd0) begin
            unique case (t)
                SRTYPE_LSL: r = '{data: op, carry: cin};
                SRTYPE_LSR: r = '{data: '0, carry: op[DATA_W-1]};
                SRTYPE_ASR: r = '{data: {DATA_W{op[DATA_W-1]}}, carry: op[DATA_W-1]};
                default:    r = '{data: {cin, op[DATA_W-1:1]}, carry: op[0]};
            endcase
        end
        return r;
    endfunction

    buf_state_e        state_q, state_d;
    logic              prio_q;
    logic              id_q;
    logic [DATA_W-1:0] data_q;
    logic              carry_q;

    logic              grant_en, gnt_idx, gnt_any;
    sh_res_t           sh_out, dec;

    always_comb begin
        grant_en = (state_q == ST_EMPTY) || rs_ready;
        gnt_idx  = (rq_valid == 2'b11) ? prio_q : rq_valid[1];
        gnt_any  = rst_n && grant_en && (rq_valid != 2'b00);
        rq_ready = gnt_any ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;
        state_d  = state_q;
        unique case (state_q)
            ST_EMPTY: if (gnt_any) state_d = ST_FULL;
            default:  if (rs_ready) state_d = gnt_any ? ST_FULL : ST_EMPTY;
        endcase
    end

    shift_arb_shifter u_shifter (
        .s_type   (rq_type[gnt_idx]),
        .offset   (rq_amt[gnt_idx][4:0]),
        .op_m     (rq_op[gnt_idx]),
        .carry_in (rq_cin[gnt_idx]),
        .result   (sh_out.data),
        .carry    (sh_out.carry)
    );

    assign dec = shift_decode(rq_type[gnt_idx], rq_is_reg[gnt_idx], rq_amt[gnt_idx],
                              rq_op[gnt_idx], rq_cin[gnt_idx], sh_out);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            prio_q  <= 1'b0;
            id_q    <= 1'b0;
            data_q  <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (gnt_any) begin
                prio_q  <= ~gnt_idx;
                id_q    <= gnt_idx;
                data_q  <= dec.data;
                carry_q <= dec.carry;
            end
        end
    end

    assign rs_valid = (state_q == ST_FULL);
    assign rs_id    = id_q;
    assign rs_data  = data_q;
    assign rs_carry = carry_q;

endmodule

// File: tb/tb_shift_arb.sv
// Directed bench for shift_arb: decode corner cases, round-robin order, backpressure, reset.
module tb_shift_arb;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       rq_valid, rq_ready;
    logic [1:0][1:0]  rq_type;
    logic [1:0]       rq_is_reg;
    logic [1:0][7:0]  rq_amt;
    logic [1:0][31:0] rq_op;
    logic [1:0]       rq_cin;
    logic             rs_valid, rs_ready, rs_id, rs_carry;
    logic [31:0]      rs_data;

    int checks = 0;
    int failures = 0;

    shift_arb dut (
        .clk(clk), .rst_n(rst_n),
        .rq_valid(rq_valid), .rq_ready(rq_ready), .rq_type(rq_type),
        .rq_is_reg(rq_is_reg), .rq_amt(rq_amt), .rq_op(rq_op), .rq_cin(rq_cin),
        .rs_valid(rs_valid), .rs_ready(rs_ready), .rs_id(rs_id),
        .rs_data(rs_data), .rs_carry(rs_carry)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic [1:0] t, input logic isr,
                            input logic [7:0] a, input logic [31:0] op, input logic cin);
        rq_type[p]   = t;
        rq_is_reg[p] = isr;
        rq_amt[p]    = a;
        rq_op[p]     = op;
        rq_cin[p]    = cin;
    endtask

    // Single-port request: granted, result checked next cycle, then drained.
    task automatic run1(input string tag, input int p, input logic [1:0] t, input logic isr,
                        input logic [7:0] a, input logic [31:0] op, input logic cin,
                        input logic [31:0] ed, input logic ec);
        set_port(p, t, isr, a, op, cin);
        rq_valid = (p == 1) ? 2'b10 : 2'b01;
        rs_ready = 1'b1;
        tick();
        rq_valid = 2'b00;
        chk({tag, ".data"},  rs_data, ed);
        chk({tag, ".carry"}, rs_carry, ec);
        chk({tag, ".id"},    rs_id, p[0]);
        tick();
    endtask

    initial begin
        rst_n = 1'b0; rq_valid = 2'b11; rs_ready = 1'b1;
        set_port(0, 2'b00, 1'b0, 8'd0, 32'h0, 1'b0);
        set_port(1, 2'b00, 1'b0, 8'd0, 32'h0, 1'b0);
        #12;
        chk("rst.rs_valid", rs_valid, 0);
        chk("rst.rs_id",    rs_id, 0);
        chk("rst.rs_data",  rs_data, 0);
        chk("rst.rs_carry", rs_carry, 0);
        chk("rst.rq_ready", rq_ready, 0);
        rq_valid = 2'b00;
        @(negedge clk); rst_n = 1'b1;
        tick();
        chk("idle.rs_valid", rs_valid, 0);

        // Basic latency
        set_port(0, 2'b00, 1'b1, 8'd4, 32'h8000_000F, 1'b0);
        rq_valid = 2'b01;
        #1 chk("lsl4.rq_ready", rq_ready, 2'b01);
        tick();
        rq_valid = 2'b00;
        chk("lsl4.valid", rs_valid, 1);
        chk("lsl4.data",  rs_data, 32'h0000_00F0);
        chk("lsl4.carry", rs_carry, 0);
        chk("lsl4.id",    rs_id, 0);
        tick();
        chk("drain.valid", rs_valid, 0);

        // Register-form corner cases
        run1("lsl32",  0, 2'b00, 1'b1, 8'd32,  32'h8000_0001, 1'b0, 32'h0, 1'b1);
        run1("lsr33",  1, 2'b01, 1'b1, 8'd33,  32'h8000_0001, 1'b1, 32'h0, 1'b0);
        run1("asr200", 0, 2'b10, 1'b1, 8'd200, 32'h8000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1);
        run1("ror64",  1, 2'b11, 1'b1, 8'd64,  32'h8000_0001, 1'b0, 32'h8000_0001, 1'b1);
        run1("amt0",   0, 2'b01, 1'b1, 8'd0,   32'h8000_0001, 1'b1, 32'h8000_0001, 1'b1);
        run1("ror8",   1, 2'b11, 1'b1, 8'd8,   32'h0000_00FF, 1'b0, 32'hFF00_0000, 1'b1);
        run1("asr4",   0, 2'b10, 1'b1, 8'd4,   32'h8000_0000, 1'b1, 32'hF800_0000, 1'b0);
        // Immediate form
        run1("rrx",    1, 2'b11, 1'b0, 8'd0,   32'h0000_0003, 1'b1, 32'h8000_0001, 1'b1);
        run1("lsri0",  0, 2'b01, 1'b0, 8'd0,   32'h0000_0003, 1'b1, 32'h0, 1'b0);
        run1("asri0",  1, 2'b10, 1'b0, 8'd0,   32'h8000_0003, 1'b0, 32'hFFFF_FFFF, 1'b1);
        run1("lsli1",  0, 2'b00, 1'b0, 8'd1,   32'h8000_0001, 1'b0, 32'h0000_0002, 1'b1);
        run1("lsri1",  1, 2'b01, 1'b0, 8'd1,   32'h0000_0003, 1'b0, 32'h0000_0001, 1'b1);
        run1("imm_hi", 0, 2'b01, 1'b0, 8'hE4,  32'h0000_00F8, 1'b0, 32'h0000_000F, 1'b1);

        // Round-robin from a clean reset: port0 -> 0xF0/C0, port1 -> 0xF/C1
        rst_n = 1'b0; #2 rst_n = 1'b1;
        set_port(0, 2'b00, 1'b1, 8'd4, 32'h8000_000F, 1'b0);
        set_port(1, 2'b01, 1'b0, 8'd4, 32'h0000_00F8, 1'b0);
        rq_valid = 2'b11; rs_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1 chk($sformatf("rr%0d.rq_ready", k), rq_ready, (k % 2) ? 2'b10 : 2'b01);
            tick();
            chk($sformatf("rr%0d.id", k), rs_id, k % 2);
            chk($sformatf("rr%0d.data", k), rs_data, (k % 2) ? 32'h0000_000F : 32'h0000_00F0);
            chk($sformatf("rr%0d.valid", k), rs_valid, 1);
        end

        // Backpressure while holding port 1's result
        rs_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1 chk($sformatf("bp%0d.rq_ready", k), rq_ready, 2'b00);
            tick();
            chk($sformatf("bp%0d.id", k), rs_id, 1);
            chk($sformatf("bp%0d.data", k), rs_data, 32'h0000_000F);
            chk($sformatf("bp%0d.carry", k), rs_carry, 1);
            chk($sformatf("bp%0d.valid", k), rs_valid, 1);
        end
        rs_ready = 1'b1;
        #1 chk("refill.rq_ready", rq_ready, 2'b01);
        tick();
        chk("refill.id",   rs_id, 0);
        chk("refill.data", rs_data, 32'h0000_00F0);

        // Reset while FULL (prio currently points at port 1)
        rst_n = 1'b0;
        #1;
        chk("midrst.valid",    rs_valid, 0);
        chk("midrst.data",     rs_data, 0);
        chk("midrst.rq_ready", rq_ready, 2'b00);
        rst_n = 1'b1;
        #1 chk("postrst.rq_ready", rq_ready, 2'b01);
        tick();
        chk("postrst.id",    rs_id, 0);
        chk("postrst.valid", rs_valid, 1);
        rq_valid = 2'b00;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL timeout: got running expected finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule

// File: doc/shift_arb.md
# shift_arb

Shared-shifter scheduler for the execute stage. Arbitrates one barrel-shifter instance between two requesters (port 0: data-processing operand-2 path, port 1: load/store scaled-offset address path) and decodes ARM register-specified and immediate shift amounts, including the special cases the combinational shifter does not cover. It registers one result and returns it over a valid/ready handshake.

## Interface
- No parameters; widths fixed at 32-bit data, 8-bit shift amount.
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- rq_valid[i], i=0,1  in  1  request i valid
- rq_ready[i]  out  1  request i granted this cycle
- rq_type[i]  in  2  00 LSL, 01 LSR, 10 ASR, 11 ROR/RRX
- rq_is_reg[i]  in  1  1 = amount from Rs[7:0]; 0 = 5-bit immediate
- rq_amt[i]  in  8  shift amount; only [4:0] used when rq_is_reg=0
- rq_op[i]  in  32  operand Rm
- rq_cin[i]  in  1  current CPSR C
- rs_valid  out  1  result valid
- rs_ready  in  1  consumer accepts result
- rs_id  out  1  requester index of held result
- rs_data  out  32  shifted value
- rs_carry  out  1  shifter carry-out

## Operation
- Output buffer FSM, states EMPTY and FULL. EMPTY->FULL on grant. In FULL: rs_ready=1 with a grant stays FULL with new contents; rs_ready=1 with no grant goes to EMPTY; rs_ready=0 holds all outputs stable.
- Grant allowed when state EMPTY, or when state FULL and rs_ready=1 (same-cycle drain and refill).
- Arbitration: round-robin. Pointer prio (reset 0) selects preferred port. If both valid, grant prio and then set prio to the other port. A single valid requester is granted regardless of prio; prio then points to the port not granted. At most one rq_ready high per cycle.
- Amount decode, register form (a = rq_amt):
  - a=0: data=op, carry=cin, all types.
  - LSL: a 1..31 via shifter; a=32: 0, carry op[0]; a>32: 0, carry 0.
  - LSR: a 1..31 via shifter; a=32: 0, carry op[31]; a>32: 0, carry 0.
  - ASR: a 1..31 via shifter; a>=32: {32{op[31]}}, carry op[31].
  - ROR: a[4:0]≠0: rotate by a[4:0] via shifter; a[4:0]=0: data=op, carry op[31].
- Amount decode, immediate form (i = rq_amt[4:0]):
  - LSL #0: data=op, carry=cin.
  - LSR #0: shift by 32, result 0, carry op[31].
  - ASR #0: shift by 32, result {32{op[31]}}, carry op[31].
  - ROR #0: RRX, {cin, op[31:1]}, carry op[0].
  - Otherwise shift by i via shifter.
- Shifter is driven only from the granted request's fields; special cases are muxed around it, never through it.

## Timing
- Latency: grant at edge N, rs_valid=1 with result after edge N (visible cycle N+1).
- Throughput: one result per cycle while rs_ready=1.
- rq_ready is combinational from rq_valid, state, rs_ready and prio; requester fields must be stable while rq_valid=1 and not yet granted.
- Reset values: rs_valid=0, rs_id=0, rs_data=0, rs_carry=0, prio=0, state EMPTY. rq_ready=0 during reset.
- Reset mid-operation: held result discarded immediately, no handshake completes.
- Backpressure: rs_ready=0 in FULL holds rs_* stable and forces both rq_ready=0.

## Structure
- Shared package shift_pkg: SRTYPE_LSL/LSR/ASR/ROR 2-bit constants, amount width (8), data width (32).
- One sub-module: the team's existing combinational shift datapath (s_type, offset, op_m, carry_in -> result, carry), instanced once.
- Decode/special-case mux as a combinational function in this block; arbiter and output register in one sequential process.

## Test plan
- Port 0 LSL, reg, amt=4, op=0x8000_000F, cin=0 -> next cycle rs_data=0x0000_00F0, rs_carry=0, rs_id=0.
- Both ports valid, continuous, rs_ready=1 -> grants alternate 0,1,0,1 starting at 0; one result per cycle.
- Register shifts op=0x8000_0001: LSL 32 -> 0/C=1; LSR 33 -> 0/C=0; ASR 200 -> 0xFFFF_FFFF/C=1; ROR 64 -> 0x8000_0001/C=1; amt 0, cin=1 -> 0x8000_0001/C=1.
- Immediate ROR #0, op=0x0000_0003, cin=1 -> 0x8000_0001, C=1; LSR #0, same op -> 0, C=0.
- rs_ready=0 for 3 cycles with both ports valid -> rs_* stable, rq_ready=0; on rs_ready=1 drain and refill same cycle.
- Assert rst_n=0 while FULL -> rs_valid=0 at once, prio=0; first grant after release goes to port 0 when both valid.
